// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed RAM with one-cycle registered read.
// Sub-word stores are done as read-modify-write. Load data is returned with sign or zero extension.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_we,
  output logic        ram_prt_en_1,
  output logic        ram_oe,
  output logic        ram_prt_en_0,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                req_bad;
  logic [31:0]         byte_shifted;
  logic [31:0]         half_shifted;
  logic [31:0]         load_data;
  logic [31:0]         merge_mask;
  logic [31:0]         merge_data;
  logic [31:0]         merged_word;

  // Request classification only looks at the live request inputs while in IDLE.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      SZ_BYTE: req_bad = 1'b0;
      default: req_bad = 1'b1;
    endcase
    if (|req_addr[31:ADDR_W+2]) req_bad = 1'b1;
  end

  always_comb begin
    byte_shifted = ram_rdata >> {addr_q[1:0], 3'b000};
    half_shifted = ram_rdata >> {addr_q[1], 4'b0000};
    case (size_q)
      SZ_BYTE: load_data = unsigned_q ? {24'h0, byte_shifted[7:0]}
                                      : {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      SZ_HALF: load_data = unsigned_q ? {16'h0, half_shifted[15:0]}
                                      : {{16{half_shifted[15]}}, half_shifted[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  // Lane merge for sub-word stores: only the addressed byte/half is replaced.
  always_comb begin
    if (size_q == SZ_HALF) begin
      merge_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      merge_data = {16'h0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
    end else begin
      merge_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      merge_data = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
    end
    merged_word = (ram_rdata & ~merge_mask) | merge_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr[ADDR_W+1:0];
            wdata_q    <= req_wdata;
            err_q      <= req_bad;
            if (req_bad) begin
              rdata_q <= 32'h0;
              state_q <= S_RESP;
            end else if (req_we && req_size == SZ_WORD) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: begin
          if (we_q) begin
            wdata_q <= merged_word;
            state_q <= S_WRITE;
          end else begin
            rdata_q <= load_data;
            state_q <= S_RESP;
          end
        end
        S_WRITE: begin
          rdata_q <= 32'h0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the state register so they can never glitch on request inputs.
  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_err     = err_q;
  assign resp_rdata   = rdata_q;
  assign ram_oe       = (state_q == S_READ);
  assign ram_prt_en_0 = (state_q == S_READ);
  assign ram_we       = (state_q == S_WRITE);
  assign ram_prt_en_1 = (state_q == S_WRITE);
  assign ram_addr     = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign ram_wdata    = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural registered-read RAM model.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic        ram_prt_en_1;
  logic        ram_oe;
  logic        ram_prt_en_0;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int pair_bad = 0;

  logic [31:0] mem [256];

  lsu_mem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .ram_we(ram_we), .ram_prt_en_1(ram_prt_en_1),
    .ram_oe(ram_oe), .ram_prt_en_0(ram_prt_en_0), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, write on strobe, no reset
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_oe) ram_rdata <= mem[ram_addr[7:0]];
  end

  always @(negedge clk) begin
    if (ram_we !== ram_prt_en_1 || ram_oe !== ram_prt_en_0) pair_bad++;
    if ((ram_we || ram_oe) && ram_addr[31:8] != 24'h0) pair_bad++;
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  // driver: one request, observe strobes and response cycle (bounded)
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int rc, output logic [31:0] rd, output logic er,
                         output int noe, output int nwe, output logic [31:0] wdat,
                         output logic [31:0] sadr, output logic rdy0);
    rc = -1; rd = 32'h0; er = 1'b0; noe = 0; nwe = 0; wdat = 32'h0; sadr = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    rdy0 = req_ready;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ram_oe) begin noe++; sadr = ram_addr; end
      if (ram_we) begin nwe++; wdat = ram_wdata; sadr = ram_addr; end
      if (resp_valid) begin rc = c; rd = resp_rdata; er = resp_err; break; end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          noe;
    int          nwe;
    logic [31:0] wdat;
    logic [31:0] sadr;
  } vec_t;

  vec_t vecs [20];

  int          rc, noe, nwe;
  logic [31:0] rd, wdat, sadr;
  logic        er, rdy0;
  int          acc_cnt, resp_cnt, good_cnt, bad_cnt;

  initial begin
    //           we    sz     uns   addr          wdata          cyc rdata          err  oe we wdat           sadr
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 2, 32'h0,        1'b0, 0, 1, 32'hDEADBEEF, 32'h4};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h13,       32'h000000A5, 4, 32'h0,        1'b0, 1, 1, 32'hA5ADBEEF, 32'h4};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        3, 32'hFFFFFFA5, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        3, 32'h000000A5, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h12,       32'h00001234, 4, 32'h0,        1'b0, 1, 1, 32'h1234BEEF, 32'h4};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h10,       32'h0,        3, 32'hFFFFBEEF, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        3, 32'h00001234, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h11,       32'h0,        1, 32'h0,        1'b1, 0, 0, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h12,       32'h00000001, 1, 32'h0,        1'b1, 0, 0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        1, 32'h0,        1'b1, 0, 0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h400,      32'h0,        1, 32'h0,        1'b1, 0, 0, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hFFFFFF7F, 4, 32'h0,        1'b0, 1, 1, 32'h00007F00, 32'h8};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        3, 32'h0000007F, 1'b0, 1, 0, 32'h0,        32'h8};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 32'h10,       32'h0,        3, 32'h000000EF, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h11,       32'h0,        3, 32'hFFFFFFBE, 1'b0, 1, 0, 32'h0,        32'h4};
    vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h3FC,      32'h80000001, 2, 32'h0,        1'b0, 0, 1, 32'h80000001, 32'hFF};
    vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h3FE,      32'h0,        3, 32'hFFFF8000, 1'b0, 1, 0, 32'h0,        32'hFF};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h3FC,      32'h0,        3, 32'h80000001, 1'b0, 1, 0, 32'h0,        32'hFF};
    vecs[19] = '{1'b0, 2'b00, 1'b0, 32'h80000000, 32'h0,        1, 32'h0,        1'b1, 0, 0, 32'h0,        32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset values in first cycle after release
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_strobes", {28'h0, ram_we, ram_prt_en_1, ram_oe, ram_prt_en_0}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);

    // table-driven vectors, each issued the cycle after the previous RESP
    for (int i = 0; i < 20; i++) begin
      run_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              rc, rd, er, noe, nwe, wdat, sadr, rdy0);
      check($sformatf("v%0d_ready", i), {31'h0, rdy0}, 32'h1);
      check($sformatf("v%0d_cycle", i), rc, vecs[i].cyc);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
      check($sformatf("v%0d_oe_pulses", i), noe, vecs[i].noe);
      check($sformatf("v%0d_we_pulses", i), nwe, vecs[i].nwe);
      check($sformatf("v%0d_ram_wdata", i), wdat, vecs[i].wdat);
      check($sformatf("v%0d_ram_addr", i), sadr, vecs[i].sadr);
    end

    // reset during WAIT of a byte store to word 4 (holds 0x1234BEEF)
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_wait", {29'h0, dbg_state}, 32'h2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    bad_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (ram_we || resp_valid) bad_cnt++;
      @(negedge clk);
    end
    check("rst_mid_no_we_resp", bad_cnt, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rd, er, noe, nwe, wdat, sadr, rdy0);
    check("rst_mid_old_word", rd, 32'h1234BEEF);
    check("rst_mid_load_cycle", rc, 3);

    // req_valid held high: one accept per 4-cycle load transaction
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    acc_cnt = 0; resp_cnt = 0; good_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready) acc_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (resp_rdata == 32'h1234BEEF && !resp_err) good_cnt++;
      end
    end
    req_valid = 1'b0;
    check("hold_accepts", acc_cnt, 3);
    check("hold_resps", resp_cnt, 3);
    check("hold_good_data", good_cnt, 3);
    repeat (2) @(negedge clk);

    check("strobe_pairing", pair_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
